// File: rtl/gaussian_pkg.sv
// Shared types and default geometry for the Gaussian filter sequencer.
package gaussian_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH  = 1920;
  localparam int unsigned DEF_HEIGHT = 1080;
  localparam int unsigned DEF_LAT    = 2;

endpackage

// File: rtl/pos_counter.sv
// Column/row raster position counter with wrap at NCOL-1 / NROW-1.
// A clear and an increment in the same cycle land on position 1.
module pos_counter
  import gaussian_pkg::*;
#(
  parameter int unsigned NCOL = DEF_WIDTH,
  parameter int unsigned NROW = DEF_HEIGHT,
  localparam int unsigned CW = $clog2(NCOL),
  localparam int unsigned RW = $clog2(NROW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          col_last_c,
  output logic          row_last_c
);

  logic [CW-1:0] col_base, col_nxt;
  logic [RW-1:0] row_base, row_nxt;

  assign col_last_c = (col == CW'(NCOL - 1));
  assign row_last_c = (row == RW'(NROW - 1));

  // Next position: optional clear first, then optional raster step
  always_comb begin
    col_base = clr ? '0 : col;
    row_base = clr ? '0 : row;
    col_nxt  = col_base;
    row_nxt  = row_base;
    if (inc) begin
      if (col_base == CW'(NCOL - 1)) begin
        col_nxt = '0;
        row_nxt = (row_base == RW'(NROW - 1)) ? '0 : row_base + RW'(1);
      end else begin
        col_nxt = col_base + CW'(1);
      end
    end
  end

  // Position register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

endmodule

// File: rtl/gaussian_seq_ctrl.sv
// Frame sequencer for the 3x3 Gaussian filter: line-buffer priming,
// end-of-frame flush, tap clock-enable, border flags and marker re-timing.
module gaussian_seq_ctrl
  import gaussian_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT,
  parameter int unsigned LAT    = DEF_LAT,
  localparam int unsigned CW = $clog2(WIDTH),
  localparam int unsigned RW = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          in_valid,
  input  logic          in_sop,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          tap_en,
  output logic          bypass,
  output logic          border_l,
  output logic          border_r,
  output logic          border_t,
  output logic          border_b,
  output logic          out_valid,
  output logic          out_sop,
  output logic          out_eop,
  output logic [CW-1:0] cen_col,
  output logic [RW-1:0] cen_row,
  output logic [1:0]    state,
  output logic          frame_err
);

  state_t        st;
  logic          acc, adv, sop_acc, cen, in_inc;
  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic          in_col_last, in_row_last, cen_col_last, cen_row_last;
  logic          prime_done, in_last, cen_first, cen_last;
  logic [LAT-1:0] vld_pipe, sop_pipe, eop_pipe;

  // Upstream is stalled during flush; everything advances only with out_ready
  assign in_ready = out_ready & (st != S_FLUSH);
  assign acc      = in_valid & in_ready;
  assign adv      = out_ready & (acc | (st == S_FLUSH));
  assign sop_acc  = acc & in_sop;
  // A restarting sop in RUN becomes pixel 0 of a new frame, not a centre
  assign cen      = adv & (((st == S_RUN) & ~in_sop) | (st == S_FLUSH));
  assign tap_en   = adv & (st != S_IDLE);
  // Pixels without sop seen in IDLE are discarded and not counted
  assign in_inc   = acc & ((st != S_IDLE) | in_sop);

  assign prime_done = (in_row == RW'(1)) & (in_col == '0);
  assign in_last    = in_col_last & in_row_last;
  assign cen_first  = (cen_col == '0) & (cen_row == '0);
  assign cen_last   = cen_col_last & cen_row_last;

  assign border_l = cen & (cen_col == '0);
  assign border_r = cen & cen_col_last;
  assign border_t = cen & (cen_row == '0);
  assign border_b = cen & cen_row_last;

  assign state     = st;
  assign out_valid = vld_pipe[LAT-1];
  assign out_sop   = sop_pipe[LAT-1];
  assign out_eop   = eop_pipe[LAT-1];

  pos_counter #(.NCOL(WIDTH), .NROW(HEIGHT)) u_in_pos (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (in_inc),
    .clr        (sop_acc),
    .col        (in_col),
    .row        (in_row),
    .col_last_c (in_col_last),
    .row_last_c (in_row_last)
  );

  pos_counter #(.NCOL(WIDTH), .NROW(HEIGHT)) u_cen_pos (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (cen),
    .clr        (sop_acc),
    .col        (cen_col),
    .row        (cen_row),
    .col_last_c (cen_col_last),
    .row_last_c (cen_row_last)
  );

  // Frame FSM with bypass latch and unexpected-sop pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      bypass    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (st)
        S_IDLE: begin
          if (sop_acc) begin
            st     <= S_PRIME;
            bypass <= ~enable;
          end
        end
        S_PRIME: begin
          if (sop_acc) begin
            frame_err <= 1'b1;
          end else if (acc && prime_done) begin
            st <= S_RUN;
          end
        end
        S_RUN: begin
          if (sop_acc) begin
            st        <= S_PRIME;
            frame_err <= 1'b1;
          end else if (acc && in_last) begin
            st <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (cen && cen_last) st <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  // Marker delay line matching the filter latency; frozen by out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      sop_pipe <= '0;
      eop_pipe <= '0;
    end else if (out_ready) begin
      vld_pipe[0] <= cen;
      sop_pipe[0] <= cen & cen_first;
      eop_pipe[0] <= cen & cen_last;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        sop_pipe[i] <= sop_pipe[i-1];
        eop_pipe[i] <= eop_pipe[i-1];
      end
    end
  end

endmodule
